// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester-side and transmitter-side signals of uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   Req;
  logic [8*N-1:0] Req_data;
  logic [2:0]     Baud_cfg;
  logic [N-1:0]   Ack;
  logic [N-1:0]   Done;
  logic [N-1:0]   Err;
  logic           Busy;
  logic           Sent_en;
  logic [7:0]     Data_byte;
  logic [2:0]     Baud_set;
  logic           Tx_done;
  logic           Uart_state;

  modport master (
    output Req, Req_data, Baud_cfg, Tx_done, Uart_state,
    input  Ack, Done, Err, Busy, Sent_en, Data_byte, Baud_set
  );

  modport slave (
    input  Req, Req_data, Baud_cfg, Tx_done, Uart_state,
    output Ack, Done, Err, Busy, Sent_en, Data_byte, Baud_set
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_byte_tx among N byte requesters.
// A granted byte and baud select are latched, Sent_en fires once, and the
// latched values stay put until the frame completes or the wait times out.
module uart_tx_arbiter #(
  parameter int N           = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int TW          = 18
) (
  input  logic             Clk,
  input  logic             Reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE    = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW:0]   N_W       = (IW+1)'(N);

  logic [1:0]    state_r;
  logic [IW-1:0] ptr_r;
  logic [IW-1:0] grant_r;
  logic [TW-1:0] tmo_cnt_r;
  logic [N-1:0]  ack_r;
  logic [N-1:0]  done_r;
  logic [N-1:0]  err_r;
  logic          busy_r;
  logic          sent_en_r;
  logic [7:0]    data_byte_r;
  logic [2:0]    baud_set_r;

  logic          win_found_s;
  logic [IW-1:0] win_idx_s;
  logic [IW-1:0] ptr_nxt_s;

  // First pending requester found walking from ptr_r upward with wrap-around.
  always_comb begin
    logic [IW:0]   cand_v;
    logic [IW-1:0] idx_v;
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    cand_v      = {(IW+1){1'b0}};
    idx_v       = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      cand_v = {1'b0, ptr_r} + (IW+1)'(i);
      if (cand_v >= N_W) begin
        cand_v = cand_v - N_W;
      end else begin
        cand_v = cand_v;
      end
      idx_v = cand_v[IW-1:0];
      if (!win_found_s && bus.Req[idx_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_v;
      end else begin
        win_found_s = win_found_s;
        win_idx_s   = win_idx_s;
      end
    end
  end

  // Pointer moves just past the requester that was served (or aborted).
  always_comb begin
    if (grant_r == LAST_IDX) begin
      ptr_nxt_s = {IW{1'b0}};
    end else begin
      ptr_nxt_s = grant_r + IW'(1);
    end
  end

  // Grant/start/wait sequencer with registered status pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {IW{1'b0}};
      grant_r     <= {IW{1'b0}};
      tmo_cnt_r   <= {TW{1'b0}};
      ack_r       <= {N{1'b0}};
      done_r      <= {N{1'b0}};
      err_r       <= {N{1'b0}};
      busy_r      <= 1'b0;
      sent_en_r   <= 1'b0;
      data_byte_r <= 8'h00;
      baud_set_r  <= 3'd0;
    end else begin
      ack_r     <= {N{1'b0}};
      done_r    <= {N{1'b0}};
      err_r     <= {N{1'b0}};
      sent_en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A transmitter still shifting out a frame is never handed a new byte.
          if (win_found_s && !bus.Uart_state) begin
            grant_r     <= win_idx_s;
            data_byte_r <= bus.Req_data[{win_idx_s, 3'b000} +: 8];
            baud_set_r  <= bus.Baud_cfg;
            state_r     <= ST_START;
            busy_r      <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_START: begin
          sent_en_r <= 1'b1;
          ack_r     <= ONE_HOT_0 << grant_r;
          tmo_cnt_r <= {TW{1'b0}};
          state_r   <= ST_WAIT;
          busy_r    <= 1'b1;
        end
        ST_WAIT: begin
          // Tx_done wins over a timeout expiring in the same cycle.
          if (bus.Tx_done) begin
            done_r  <= ONE_HOT_0 << grant_r;
            ptr_r   <= ptr_nxt_s;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (tmo_cnt_r == TO_LAST) begin
            err_r   <= ONE_HOT_0 << grant_r;
            ptr_r   <= ptr_nxt_s;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TO_ONE;
            busy_r    <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ack       = ack_r;
  assign bus.Done      = done_r;
  assign bus.Err       = err_r;
  assign bus.Busy      = busy_r;
  assign bus.Sent_en   = sent_en_r;
  assign bus.Data_byte = data_byte_r;
  assign bus.Baud_set  = baud_set_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N=4, TIMEOUT_CYC=100) with a stub
// transmitter and a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 100;

  logic Clk;
  logic Reset;
  int   cyc;
  int   vectors;
  int   miscompares;

  bit stub_en;
  bit stub_never;
  int stub_len;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(.N(N), .TIMEOUT_CYC(TO), .TW(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Cycle counter shared by model and stimulus.
  always @(posedge Clk) cyc <= cyc + 1;

  // Reference model state: one outstanding transaction described by timestamps.
  bit         m_valid;
  bit         m_active;
  int         m_w;
  int         m_sent;
  int         m_ptr;
  logic [7:0] m_byte;
  logic [2:0] m_baud;
  logic [3:0] m_done;
  logic [3:0] m_err;

  // Compare on every falling edge, then advance the model with this cycle's inputs.
  initial begin : model
    logic [24:0] act_v;
    logic [24:0] exp_v;
    bit          found;
    bit          snt;
    int          j;
    m_valid = 1'b0;
    m_active = 1'b0; m_w = 0; m_sent = 0; m_ptr = 0;
    m_byte = 8'h00; m_baud = 3'd0; m_done = 4'b0; m_err = 4'b0;
    forever begin
      @(negedge Clk);
      if (m_valid) begin
        snt   = m_active && (cyc == m_sent);
        exp_v = {snt, snt ? 4'(1 << m_w) : 4'b0000, m_done, m_err, m_active, m_byte, m_baud};
        act_v = {bus.Sent_en, bus.Ack, bus.Done, bus.Err, bus.Busy, bus.Data_byte, bus.Baud_set};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL cycle %0d outputs {sent,ack,done,err,busy,byte,baud}: got %h required %h", cyc, act_v, exp_v);
        end
      end
      if (Reset) begin
        m_valid = 1'b1; m_active = 1'b0; m_w = 0; m_ptr = 0;
        m_byte = 8'h00; m_baud = 3'd0; m_done = 4'b0; m_err = 4'b0;
      end else begin
        m_done = 4'b0;
        m_err  = 4'b0;
        if (m_active && cyc >= m_sent) begin
          if (bus.Tx_done) begin
            m_done = 4'(1 << m_w); m_active = 1'b0; m_ptr = (m_w + 1) % N;
          end else if (cyc - m_sent == TO - 1) begin
            m_err = 4'(1 << m_w); m_active = 1'b0; m_ptr = (m_w + 1) % N;
          end
        end else if (!m_active && bus.Req != 4'b0 && !bus.Uart_state) begin
          found = 1'b0;
          for (int i = 0; i < N; i++) begin
            j = (m_ptr + i) % N;
            if (!found && bus.Req[j]) begin
              found = 1'b1;
              m_w = j;
            end
          end
          m_byte   = bus.Req_data[8*m_w +: 8];
          m_baud   = bus.Baud_cfg;
          m_active = 1'b1;
          m_sent   = cyc + 2;
        end
      end
    end
  end

  // Stub uart_byte_tx: busy for stub_len cycles after Sent_en, then a Tx_done pulse.
  initial begin : stub
    int cnt;
    bit rs;
    bit pulse;
    cnt = 0;
    pulse = 1'b0;
    forever begin
      @(posedge Clk);
      rs = Reset;
      #2;
      if (stub_en) begin
        if (pulse) begin
          bus.Tx_done = 1'b0;
          pulse = 1'b0;
        end
        if (rs) begin
          cnt = 0;
          bus.Uart_state = 1'b0;
        end else if (bus.Sent_en && !stub_never) begin
          cnt = stub_len;
          bus.Uart_state = 1'b1;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.Tx_done = 1'b1;
            bus.Uart_state = 1'b0;
            pulse = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // kind 0 = Sent_en, 1 = any Done, 2 = any Err; returns the cycle it was seen.
  task automatic wait_ev(input int kind, input int bound, output int at);
    bit hit;
    hit = 1'b0;
    at = -1;
    for (int k = 0; k < bound && !hit; k++) begin
      @(posedge Clk);
      #2;
      case (kind)
        0:       hit = bus.Sent_en;
        1:       hit = |bus.Done;
        default: hit = |bus.Err;
      endcase
      if (hit) at = cyc;
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_kind%0d: got no event in %0d cycles, required one", kind, bound);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
  endtask

  initial begin : stim
    int at;
    int k0;
    int s;
    logic [7:0] rr_b [0:4];
    logic [3:0] rr_a [0:4];
    rr_b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    rr_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    Reset = 1'b1;
    bus.Req = 4'b0; bus.Req_data = 32'h0; bus.Baud_cfg = 3'd0;
    bus.Tx_done = 1'b0; bus.Uart_state = 1'b0;
    stub_en = 1'b1; stub_never = 1'b0; stub_len = 12;
    step(3);
    Reset = 1'b0;
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    chk("reset_byte", 32'(bus.Data_byte), 32'h00);
    chk("reset_baud", 32'(bus.Baud_set), 32'd0);

    // Single request.
    bus.Req = 4'b0001; bus.Req_data = 32'h0000_0063; bus.Baud_cfg = 3'b100;
    k0 = cyc;
    wait_ev(0, 20, s);
    bus.Req = 4'b0;
    chk("single_sent_lat", 32'(s - k0), 32'd2);
    chk("single_ack", 32'(bus.Ack), 32'b0001);
    chk("single_byte", 32'(bus.Data_byte), 32'h63);
    chk("single_baud", 32'(bus.Baud_set), 32'd4);
    wait_ev(1, 40, at);
    chk("single_done_lat", 32'(at - s), 32'd13);
    chk("single_done", 32'(bus.Done), 32'b0001);
    chk("single_busy_after", 32'(bus.Busy), 32'd0);

    // Round robin with all four requesting.
    pulse_reset();
    stub_len = 5;
    bus.Req = 4'b1111; bus.Req_data = 32'hA3A2_A1A0; bus.Baud_cfg = 3'd2;
    for (int i = 0; i < 5; i++) begin
      wait_ev(0, 40, at);
      chk("rr_byte", 32'(bus.Data_byte), 32'(rr_b[i]));
      chk("rr_ack", 32'(bus.Ack), 32'(rr_a[i]));
      if (i == 4) bus.Req = 4'b0;
    end
    wait_ev(1, 40, at);
    step(2);

    // Pointer wrap: serve 2, then 0 wins over 2 from ptr=3.
    pulse_reset();
    bus.Req = 4'b0100; bus.Req_data = 32'h4433_2211;
    wait_ev(0, 20, at);
    bus.Req = 4'b0;
    wait_ev(1, 40, at);
    chk("wrap_model_ptr", 32'(m_ptr), 32'd3);
    bus.Req = 4'b0101;
    wait_ev(0, 20, at);
    bus.Req = 4'b0;
    chk("wrap_ack", 32'(bus.Ack), 32'b0001);
    chk("wrap_byte", 32'(bus.Data_byte), 32'h11);
    wait_ev(1, 40, at);

    // Timeout on requester 1, then requester 0 granted.
    stub_never = 1'b1;
    bus.Req = 4'b0011;
    wait_ev(0, 20, s);
    bus.Req = 4'b0001;
    chk("to_ack", 32'(bus.Ack), 32'b0010);
    wait_ev(2, 150, at);
    stub_never = 1'b0;
    chk("to_err_lat", 32'(at - s), 32'd100);
    chk("to_err", 32'(bus.Err), 32'b0010);
    chk("to_no_done", 32'(bus.Done), 32'b0000);
    k0 = at;
    wait_ev(0, 20, s);
    bus.Req = 4'b0;
    chk("to_next_lat", 32'(s - k0), 32'd2);
    chk("to_next_ack", 32'(bus.Ack), 32'b0001);
    wait_ev(1, 40, at);
    step(2);

    // Busy transmitter holds off the grant.
    stub_en = 1'b0;
    bus.Uart_state = 1'b1;
    bus.Req = 4'b0001;
    step(5);
    chk("busy_tx_no_sent", 32'(bus.Sent_en), 32'd0);
    chk("busy_tx_idle", 32'(bus.Busy), 32'd0);
    bus.Uart_state = 1'b0;
    k0 = cyc;
    wait_ev(0, 20, s);
    bus.Req = 4'b0;
    chk("busy_tx_lat", 32'(s - k0), 32'd2);
    // Tx_done exactly on the expiry cycle.
    step(99);
    bus.Tx_done = 1'b1;
    step(1);
    bus.Tx_done = 1'b0;
    chk("coinc_done", 32'(bus.Done), 32'b0001);
    chk("coinc_err", 32'(bus.Err), 32'b0000);
    step(2);

    // Reset in the middle of a frame.
    stub_en = 1'b1;
    stub_len = 30;
    bus.Req = 4'b1000; bus.Req_data = 32'hD3C2_B1A0; bus.Baud_cfg = 3'd6;
    wait_ev(0, 20, s);
    bus.Req = 4'b0;
    chk("mid_ack", 32'(bus.Ack), 32'b1000);
    step(5);
    pulse_reset();
    chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
    chk("mid_rst_byte", 32'(bus.Data_byte), 32'h00);
    chk("mid_rst_baud", 32'(bus.Baud_set), 32'd0);
    chk("mid_rst_model_ptr", 32'(m_ptr), 32'd0);
    step(40);
    bus.Req = 4'b1001;
    wait_ev(0, 20, s);
    bus.Req = 4'b0;
    chk("mid_ptr_zero_ack", 32'(bus.Ack), 32'b0001);
    chk("mid_ptr_zero_byte", 32'(bus.Data_byte), 32'hA0);
    wait_ev(1, 60, at);
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_byte_tx instance among N byte requesters using round-robin arbitration.
- Latches the winning requester's byte and fires a single-cycle Sent_en, then holds Data_byte/Baud_set stable until Tx_done.
- Reports per-requester accept/done/error pulses.
- Sits between the data-transfer logic and uart_byte_tx; owns every control input of the transmitter.

Parameters:
- N, 4, number of requesters (2..8)
- TIMEOUT_CYC, 200000, max cycles waiting for Tx_done before abort (≥ one 9600-baud frame at 50 MHz)
- TW, 18, width of timeout counter; must satisfy 2^TW > TIMEOUT_CYC

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Req  in  N  per-requester byte request, level; bit i high = byte pending
- Req_data  in  8*N  byte for requester i at [8i+7:8i]
- Baud_cfg  in  3  baud select; sampled at grant
- Ack  out  N  one-hot, 1-cycle pulse: requester's byte latched, may change Req_data/drop Req
- Done  out  N  one-hot, 1-cycle pulse: requester's byte fully transmitted
- Err  out  N  one-hot, 1-cycle pulse: requester's byte aborted on timeout
- Busy  out  1  high in any state except IDLE
- Sent_en  out  1  to uart_byte_tx, 1-cycle start pulse
- Data_byte  out  8  to uart_byte_tx, stable from Sent_en until Tx_done
- Baud_set  out  3  to uart_byte_tx, stable from Sent_en until Tx_done
- Tx_done  in  1  from uart_byte_tx, 1-cycle frame-complete pulse
- Uart_state  in  1  from uart_byte_tx, high while transmitting

Behaviour:
- Reset: state=IDLE; Ack=Done=Err=0; Busy=0; Sent_en=0; Data_byte=8'h00; Baud_set=3'd0; rr pointer=0; grant index=0; timeout counter=0. Reset mid-frame aborts silently with no Err; transmitter is reset by its own reset.
- FSM states: IDLE, START, WAIT.
- IDLE:
  - If |Req and Uart_state==0, select winner w = first set Req bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Register w, Data_byte<=Req_data[w], Baud_set<=Baud_cfg; go to START.
  - If Uart_state==1, stay in IDLE: the transmitter is not accepted while busy.
- START (exactly 1 cycle): Sent_en=1, Ack[w]=1, timeout counter cleared; go to WAIT.
- WAIT:
  - Count cycles.
  - On Tx_done: Done[w]=1 in the next cycle (registered); ptr<=(w+1) mod N; go to IDLE.
  - If count reaches TIMEOUT_CYC-1 without Tx_done: Err[w]=1 next cycle; ptr<=(w+1) mod N; go to IDLE.
  - Tx_done in the same cycle as timeout expiry counts as Done, not Err.
- Latency:
  - Req rising at cycle k (arbiter idle, Uart_state low) gives Sent_en and Ack at k+2; w is registered at k+1.
  - Done pulse appears 1 cycle after Tx_done.
  - Next grant can start 1 cycle after Done: IDLE re-evaluates in the Done cycle.
- Sampling: Req and Req_data of the winner are sampled only in the IDLE decision cycle. Changes during START/WAIT are ignored. A requester keeping Req high after Ack is treated as a new request.
- Fairness: a continuously asserted requester waits at most N-1 frames.
- Busy = (state != IDLE).
- Tx_done outside WAIT is ignored.
- Ack, Done and Err are never asserted together for different i in the same cycle.

Test Plan:
- Single request: Req=4'b0001, Req_data[7:0]=8'h63, Baud_cfg=3'b100 → Sent_en and Ack=0001 together for 1 cycle; Data_byte=8'h63 and Baud_set=4 held until Tx_done; Done=0001 1 cycle after Tx_done; Busy low afterwards.
- Round-robin: all four Req held high with bytes 8'hA0..8'hA3 → transmitted order A0, A1, A2, A3, A0; each Ack one-hot in order 0001, 0010, 0100, 1000.
- Pointer wrap: ptr=3 after serving requester 2, Req=4'b0101 → requester 0 is granted next (search 3→0).
- Timeout: stub transmitter never pulses Tx_done, TIMEOUT_CYC=100 → Err[w] pulses 100 cycles after Sent_en; next pending requester is granted; no Done for w.
- Busy transmitter / simultaneity: Uart_state=1 with Req=0001 → no Sent_en until Uart_state=0. Tx_done coincident with timeout expiry → Done pulse, Err stays 0.
- Reset mid-WAIT: assert Reset for 1 cycle during a frame → all outputs return to reset values next cycle, no Done/Err for the aborted byte, ptr=0.
